mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage; sits directly downstream of the execute stage and upstream of writeback.
- Latches the execute stage's per-instruction fields and receives synchronous data-SRAM read data one cycle after the request.
- Performs load byte/halfword selection and sign/zero extension, then selects the final register result.
- Drives the writeback bus and a forwarding bus back to decode, under the standard valid/allowin pipeline handshake.

Parameters:
- XLEN, 32, datapath and address width.
- RAW, 5, register-index width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- in_valid  in  1  upstream instruction valid
- mem_allowin  out  1  stage can accept this cycle
- in_pc  in  XLEN  instruction PC
- in_gr_we  in  1  writes register file
- in_dest  in  RAW  destination register
- in_exe_result  in  XLEN  ALU/mul/div result; memory address for loads/stores
- in_store  in  1  instruction is a store
- in_load_op  in  5  one-hot load type: [4]LD_W [3]LD_H [2]LD_HU [1]LD_B [0]LD_BU
- in_rfrom_mem  in  1  result comes from memory (load)
- data_sram_rdata  in  XLEN  SRAM read data; valid exactly one cycle after request
- wb_allowin  in  1  writeback can accept
- mem_to_wb_valid  out  1  instruction handed to writeback
- wb_pc  out  XLEN  PC to writeback
- wb_gr_we  out  1  gated by internal valid
- wb_dest  out  RAW  destination register
- wb_result  out  XLEN  final result
- fwd_dest  out  RAW  dest if valid & gr_we, else 0
- fwd_result  out  XLEN  equals wb_result

Behaviour:
- Reset:
  - valid=0 and all latched fields=0.
  - buf_vld=0.
  - All outputs therefore read 0, except mem_allowin=1.
- Handshake:
  - ready_go=1 always.
  - mem_allowin = !valid | wb_allowin.
  - mem_to_wb_valid = valid.
  - When mem_allowin=1, valid <= in_valid.
  - Fields latch only when in_valid & mem_allowin.
- Read-data capture:
  - State buf_vld is clear (DIRECT) while the live SRAM data applies, set (HELD) once data is buffered.
  - The first cycle an instruction is resident, the live data_sram_rdata is valid.
  - If valid & in_rfrom_mem_latched & !buf_vld & !wb_allowin: rdata_buf <= data_sram_rdata and buf_vld <= 1.
  - Any acceptance (in_valid & mem_allowin) forces buf_vld <= 0; acceptance has priority over capture.
  - Effective rdata = buf_vld ? rdata_buf : data_sram_rdata.
  - Rationale: upstream keeps re-issuing reads while stalled, so live rdata is only trustworthy in the first resident cycle.
- Load extraction:
  - off = exe_result[1:0]; byte = rdata[8*off +: 8]; half = off[1] ? rdata[31:16] : rdata[15:0].
  - LD_W -> rdata; LD_B/LD_H -> sign-extend; LD_BU/LD_HU -> zero-extend.
  - Misaligned halfword (off[0]=1): extract per off[1] only, no fault (baseline).
- Result select: wb_result = rfrom_mem ? load_data : exe_result. Stores pass through with gr_we=0 from upstream.
- Simultaneous events:
  - Drain and accept in the same cycle: new instruction enters in DIRECT state.
  - Reset mid-stall: the held instruction is discarded and buf_vld cleared.
- Latency: one cycle from acceptance to mem_to_wb_valid, if wb_allowin.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- With the macro:
  - Adds output mem_ale (1 bit, reset 0).
  - mem_ale is asserted while valid and the instruction is misaligned: LD_W/store word with off!=0, or LD_H/LD_HU with off[0]=1.
  - While asserted, wb_gr_we and fwd_dest are forced to 0.
  - The store case uses an added input in_store_w (1 bit).
- Without the macro: no mem_ale port; misalignment is silently handled as in Behaviour.

Decomposition:
- Shared package: load_op bit indices (LD_W..LD_BU), XLEN/RAW defaults, writeback bus field widths.
- One natural sub-module: load_extend (combinational; inputs rdata, off, load_op; output load_data). The stage keeps all sequential state.

Test Plan:
- LD_B, exe_result=0x1003, rdata=0x80FF_1234, wb_allowin=1 -> next cycle wb_result=0xFFFF_FF80, wb_dest as issued.
- LD_HU, off=2, rdata=0x8001_0000 -> wb_result=0x0000_8001; LD_H same inputs -> 0xFFFF_8001.
- LD_W accepted with rdata=0xDEAD_BEEF, wb_allowin=0 for 3 cycles while rdata toggles to 0x1111_1111 -> wb_result stays 0xDEAD_BEEF; released on wb_allowin=1.
- Non-load, gr_we=1, dest=5, exe_result=0x42 -> fwd_dest=5, fwd_result=0x42; with valid=0 -> fwd_dest=0.
- Back-to-back loads with wb_allowin=1 every cycle -> each result uses its own live rdata; buf_vld never set.
- Reset asserted during a stalled load -> next cycle mem_to_wb_valid=0, mem_allowin=1, fwd_dest=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the memory-access stage.
//   - default datapath / register-index widths
//   - one-hot load_op bit positions (LD_W..LD_BU)
//   - writeback bus field widths
//   - read-data capture state encoding
package mem_stage_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int RAW_DEF   = 5;
  localparam int LOAD_OP_W = 5;

  // one-hot load_op bit positions
  localparam int LD_W  = 4;
  localparam int LD_H  = 3;
  localparam int LD_HU = 2;
  localparam int LD_B  = 1;
  localparam int LD_BU = 0;

  // writeback bus fields: pc, gr_we, dest, result
  localparam int WB_PC_W     = XLEN_DEF;
  localparam int WB_GR_WE_W  = 1;
  localparam int WB_DEST_W   = RAW_DEF;
  localparam int WB_RESULT_W = XLEN_DEF;
  localparam int WB_BUS_W    = WB_PC_W + WB_GR_WE_W + WB_DEST_W + WB_RESULT_W;

  typedef enum logic {
    RD_DIRECT = 1'b0,
    RD_HELD   = 1'b1
  } rd_state_e;

endpackage

// File: rtl/mem_stage_load_extend.sv
// load_extend: combinational load byte/halfword selection and extension.
// Ports:
//   rdata     in  XLEN       raw word read from the data SRAM
//   off       in  2          byte offset within the word (address[1:0])
//   load_op   in  LOAD_OP_W  one-hot load type
//   load_data out XLEN       extracted and extended load value
// Misaligned halfwords (off[0]=1) select a half by off[1] alone; no fault.
module load_extend
  import mem_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0]      rdata,
  input  logic [1:0]           off,
  input  logic [LOAD_OP_W-1:0] load_op,
  output logic [XLEN-1:0]      load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_data = rdata;
    if (load_op[LD_B])
      load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
    else if (load_op[LD_BU])
      load_data = {{(XLEN-8){1'b0}}, byte_sel};
    else if (load_op[LD_H])
      load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
    else if (load_op[LD_HU])
      load_data = {{(XLEN-16){1'b0}}, half_sel};
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and writeback.
// Latches execute-stage fields, takes synchronous SRAM read data one cycle
// after the request, extracts/extends load data and drives the writeback
// and forwarding buses under the valid/allowin handshake.
// Ports:
//   clk, resetn (synchronous, active-low)
//   in_valid / mem_allowin            upstream handshake
//   in_pc, in_gr_we, in_dest, in_exe_result, in_store, in_load_op,
//   in_rfrom_mem                      execute-stage fields
//   data_sram_rdata                   SRAM read data
//   wb_allowin / mem_to_wb_valid      downstream handshake
//   wb_pc, wb_gr_we, wb_dest, wb_result   writeback bus
//   fwd_dest, fwd_result              forwarding bus to decode
// Build option MEM_ALIGN_CHECK_EN: adds input in_store_w and output mem_ale
// flagging misaligned word/halfword accesses and suppressing the write.
//
// Read-data capture FSM:
//   state     | meaning
//   RD_DIRECT | live data_sram_rdata is valid for the resident instruction
//   RD_HELD   | load data was captured in rdata_buf during a stall
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RAW  = RAW_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 mem_allowin,
  input  logic [XLEN-1:0]      in_pc,
  input  logic                 in_gr_we,
  input  logic [RAW-1:0]       in_dest,
  input  logic [XLEN-1:0]      in_exe_result,
  input  logic                 in_store,
  input  logic [LOAD_OP_W-1:0] in_load_op,
  input  logic                 in_rfrom_mem,
`ifdef MEM_ALIGN_CHECK_EN
  input  logic                 in_store_w,
  output logic                 mem_ale,
`endif
  input  logic [XLEN-1:0]      data_sram_rdata,
  input  logic                 wb_allowin,
  output logic                 mem_to_wb_valid,
  output logic [XLEN-1:0]      wb_pc,
  output logic                 wb_gr_we,
  output logic [RAW-1:0]       wb_dest,
  output logic [XLEN-1:0]      wb_result,
  output logic [RAW-1:0]       fwd_dest,
  output logic [XLEN-1:0]      fwd_result
);

  logic                 valid;
  logic [XLEN-1:0]      pc;
  logic                 gr_we;
  logic [RAW-1:0]       dest;
  logic [XLEN-1:0]      exe_result;
  logic [LOAD_OP_W-1:0] load_op;
  logic                 rfrom_mem;
  logic [XLEN-1:0]      rdata_buf;
  rd_state_e            rd_state, rd_state_nxt;

  logic                 accept;
  logic                 capture;
  logic [XLEN-1:0]      rdata_eff;
  logic [XLEN-1:0]      load_data;
  logic                 ale;
  logic                 write_ok;

  assign mem_allowin     = !valid || wb_allowin;
  assign accept          = in_valid && mem_allowin;
  assign mem_to_wb_valid = valid;

  // Upstream keeps re-issuing the read while stalled, so the live data is
  // trusted only in the first resident cycle; a stall captures it.
  always_comb begin
    rd_state_nxt = rd_state;
    if (accept)
      rd_state_nxt = RD_DIRECT;
    else if (valid && rfrom_mem && rd_state == RD_DIRECT && !wb_allowin)
      rd_state_nxt = RD_HELD;
  end

  assign capture = (rd_state == RD_DIRECT) && (rd_state_nxt == RD_HELD);

  always_ff @(posedge clk) begin
    if (!resetn) rd_state <= RD_DIRECT;
    else         rd_state <= rd_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid      <= 1'b0;
      pc         <= '0;
      gr_we      <= 1'b0;
      dest       <= '0;
      exe_result <= '0;
      load_op    <= '0;
      rfrom_mem  <= 1'b0;
      rdata_buf  <= '0;
    end else begin
      if (mem_allowin) valid <= in_valid;
      if (accept) begin
        pc         <= in_pc;
        gr_we      <= in_gr_we;
        dest       <= in_dest;
        exe_result <= in_exe_result;
        load_op    <= in_load_op;
        rfrom_mem  <= in_rfrom_mem;
      end
      if (capture) rdata_buf <= data_sram_rdata;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic store_word;

  always_ff @(posedge clk) begin
    if (!resetn)     store_word <= 1'b0;
    else if (accept) store_word <= in_store && in_store_w;
  end

  assign ale = valid &&
               (((load_op[LD_W] || store_word) && (exe_result[1:0] != 2'd0)) ||
                ((load_op[LD_H] || load_op[LD_HU]) && exe_result[0]));
  assign mem_ale = ale;
`else
  logic unused_store;
  assign unused_store = in_store;
  assign ale = 1'b0;
`endif

  assign rdata_eff = (rd_state == RD_HELD) ? rdata_buf : data_sram_rdata;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .rdata     (rdata_eff),
    .off       (exe_result[1:0]),
    .load_op   (load_op),
    .load_data (load_data)
  );

  assign write_ok   = valid && gr_we && !ale;
  assign wb_pc      = pc;
  assign wb_gr_we   = write_ok;
  assign wb_dest    = dest;
  assign wb_result  = rfrom_mem ? load_data : exe_result;
  assign fwd_dest   = write_ok ? dest : '0;
  assign fwd_result = wb_result;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        mem_allowin;
  logic [31:0] in_pc;
  logic        in_gr_we;
  logic [4:0]  in_dest;
  logic [31:0] in_exe_result;
  logic        in_store;
  logic [4:0]  in_load_op;
  logic        in_rfrom_mem;
  logic [31:0] data_sram_rdata;
  logic        wb_allowin;
  logic        mem_to_wb_valid;
  logic [31:0] wb_pc;
  logic        wb_gr_we;
  logic [4:0]  wb_dest;
  logic [31:0] wb_result;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_result;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .in_valid        (in_valid),
    .mem_allowin     (mem_allowin),
    .in_pc           (in_pc),
    .in_gr_we        (in_gr_we),
    .in_dest         (in_dest),
    .in_exe_result   (in_exe_result),
    .in_store        (in_store),
    .in_load_op      (in_load_op),
    .in_rfrom_mem    (in_rfrom_mem),
    .data_sram_rdata (data_sram_rdata),
    .wb_allowin      (wb_allowin),
    .mem_to_wb_valid (mem_to_wb_valid),
    .wb_pc           (wb_pc),
    .wb_gr_we        (wb_gr_we),
    .wb_dest         (wb_dest),
    .wb_result       (wb_result),
    .fwd_dest        (fwd_dest),
    .fwd_result      (fwd_result)
  );

  typedef struct {
    logic [4:0]  op;
    logic        rfm;
    logic        gr_we;
    logic        store;
    logic [4:0]  dest;
    logic [31:0] exe;
    logic [31:0] rdata;
    logic [31:0] exp_result;
    logic [4:0]  exp_fwd;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] op,
                       input logic rfm, input logic gr_we, input logic store,
                       input logic [4:0] dest, input logic [31:0] exe);
    in_valid = v; in_pc = pc; in_load_op = op; in_rfrom_mem = rfm;
    in_gr_we = gr_we; in_store = store; in_dest = dest; in_exe_result = exe;
  endtask

  // Reference result computed directly from the load rules with arithmetic.
  function automatic logic [31:0] ref_result(input logic rfm, input logic [4:0] op,
                                             input logic [31:0] exe, input logic [31:0] rd);
    int unsigned off, b, h;
    off = exe % 4;
    b = (rd >> (8 * off)) & 32'hFF;
    h = ((off >= 2) ? (rd >> 16) : rd) & 32'hFFFF;
    if (!rfm) return exe;
    if (op[1]) return (b >= 128) ? b + 32'hFFFF_FF00 : b;
    if (op[0]) return b;
    if (op[3]) return (h >= 32768) ? h + 32'hFFFF_0000 : h;
    if (op[2]) return h;
    return rd;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{5'b00010, 1, 1, 0, 5'd7,  32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80, 5'd7};
    vecs[1] = '{5'b00100, 1, 1, 0, 5'd8,  32'h0000_2002, 32'h8001_0000, 32'h0000_8001, 5'd8};
    vecs[2] = '{5'b01000, 1, 1, 0, 5'd9,  32'h0000_2002, 32'h8001_0000, 32'hFFFF_8001, 5'd9};
    vecs[3] = '{5'b00001, 1, 1, 0, 5'd10, 32'h0000_3001, 32'h0000_9A00, 32'h0000_009A, 5'd10};
    vecs[4] = '{5'b10000, 1, 1, 0, 5'd11, 32'h0000_4000, 32'h1234_5678, 32'h1234_5678, 5'd11};
    vecs[5] = '{5'b00000, 0, 1, 0, 5'd5,  32'h0000_0042, 32'hFFFF_FFFF, 32'h0000_0042, 5'd5};
    vecs[6] = '{5'b01000, 1, 1, 0, 5'd12, 32'h0000_5001, 32'h1234_8765, 32'hFFFF_8765, 5'd12};
    vecs[7] = '{5'b00000, 0, 0, 1, 5'd3,  32'h0000_0100, 32'h5555_AAAA, 32'h0000_0100, 5'd0};

    resetn = 1'b0; wb_allowin = 1'b1; data_sram_rdata = '0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    chk("reset_allowin", {31'd0, mem_allowin}, 32'd1);
    chk("reset_valid", {31'd0, mem_to_wb_valid}, 32'd0);
    chk("reset_result", wb_result, 32'd0);
    chk("reset_pc", wb_pc, 32'd0);
    chk("reset_fwd_dest", {27'd0, fwd_dest}, 32'd0);
    chk("reset_gr_we", {31'd0, wb_gr_we}, 32'd0);
    #1;

    // table-driven single instructions
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h100 + 4 * i, vecs[i].op, vecs[i].rfm, vecs[i].gr_we, vecs[i].store,
            vecs[i].dest, vecs[i].exe);
      wb_allowin = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      data_sram_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("vec%0d_valid", i), {31'd0, mem_to_wb_valid}, 32'd1);
      chk($sformatf("vec%0d_result", i), wb_result, vecs[i].exp_result);
      chk($sformatf("vec%0d_fwd_result", i), fwd_result, vecs[i].exp_result);
      chk($sformatf("vec%0d_fwd_dest", i), {27'd0, fwd_dest}, {27'd0, vecs[i].exp_fwd});
      chk($sformatf("vec%0d_wb_dest", i), {27'd0, wb_dest}, {27'd0, vecs[i].dest});
      chk($sformatf("vec%0d_pc", i), wb_pc, 32'h100 + 4 * i);
    end
    @(posedge clk); #2;
    chk("idle_valid", {31'd0, mem_to_wb_valid}, 32'd0);
    chk("idle_fwd_dest", {27'd0, fwd_dest}, 32'd0);
    chk("idle_gr_we", {31'd0, wb_gr_we}, 32'd0);

    // stalled LD_W: first-cycle data must be held while rdata toggles
    drive(1, 32'h200, 5'b10000, 1, 1, 0, 5'd4, 32'h0000_6000);
    @(posedge clk); #1;
    in_valid = 1'b0; wb_allowin = 1'b0; data_sram_rdata = 32'hDEAD_BEEF;
    #1 chk("stall_first", wb_result, 32'hDEAD_BEEF);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      data_sram_rdata = (c % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222;
      #1;
      chk($sformatf("stall_hold%0d", c), wb_result, 32'hDEAD_BEEF);
      chk($sformatf("stall_allowin%0d", c), {31'd0, mem_allowin}, 32'd0);
    end
    // drain and accept together: new load must use live data
    wb_allowin = 1'b1;
    drive(1, 32'h204, 5'b10000, 1, 1, 0, 5'd6, 32'h0000_6004);
    #1 chk("release_result", wb_result, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    in_valid = 1'b0; data_sram_rdata = 32'hCAFE_0001;
    #1;
    chk("swap_direct", wb_result, 32'hCAFE_0001);
    chk("swap_dest", {27'd0, wb_dest}, 32'd6);

    // back-to-back loads, each with its own live data
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(1, 32'h300 + 4 * i, 5'b00010 << (i % 3), 1, 1, 0, 5'(i + 1), 32'h7000 + i);
      data_sram_rdata = 32'h8182_8384 + 32'h0101_0101 * i;
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      data_sram_rdata = 32'hF0E0_D0C0 ^ (32'h1111_1111 * i);
      #1 chk($sformatf("b2b%0d", i), wb_result,
             ref_result(1, 5'b00010 << (i % 3), 32'h7000 + i, 32'hF0E0_D0C0 ^ (32'h1111_1111 * i)));
    end

    // reset during a stalled load
    @(posedge clk); #1;
    drive(1, 32'h400, 5'b10000, 1, 1, 0, 5'd9, 32'h8000);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0); wb_allowin = 1'b0; data_sram_rdata = 32'h3333_3333;
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    #1;
    chk("rst_stall_valid", {31'd0, mem_to_wb_valid}, 32'd0);
    chk("rst_stall_allowin", {31'd0, mem_allowin}, 32'd1);
    chk("rst_stall_fwd", {27'd0, fwd_dest}, 32'd0);
    #1;

    // randomized traffic against a transaction-level model
    begin
      logic        m_valid = 1'b0, m_fresh = 1'b0;
      logic [31:0] m_pc = '0, m_exe = '0, m_data = '0;
      logic [4:0]  m_op = '0, m_dest = '0;
      logic        m_rfm = 1'b0, m_gr_we = 1'b0;
      logic        rfm;
      for (int k = 0; k < 400; k++) begin
        rfm = 1'($urandom % 2);
        drive(1'($urandom % 3 != 0), $urandom, rfm ? 5'(1 << ($urandom % 5)) : 5'd0,
              rfm, 1'($urandom % 2), 1'b0, 5'($urandom), $urandom);
        wb_allowin = 1'($urandom % 4 != 0);
        data_sram_rdata = $urandom;
        if (m_valid && m_fresh) m_data = data_sram_rdata;
        #2;
        chk("rnd_allowin", {31'd0, mem_allowin}, {31'd0, !m_valid || wb_allowin});
        chk("rnd_valid", {31'd0, mem_to_wb_valid}, {31'd0, m_valid});
        chk("rnd_gr_we", {31'd0, wb_gr_we}, {31'd0, m_valid && m_gr_we});
        chk("rnd_fwd_dest", {27'd0, fwd_dest}, (m_valid && m_gr_we) ? {27'd0, m_dest} : 32'd0);
        if (m_valid) begin
          chk("rnd_result", wb_result, ref_result(m_rfm, m_op, m_exe, m_data));
          chk("rnd_pc", wb_pc, m_pc);
          chk("rnd_dest", {27'd0, wb_dest}, {27'd0, m_dest});
        end
        m_fresh = 1'b0;
        if (!m_valid || wb_allowin) begin
          m_valid = in_valid;
          if (in_valid) begin
            m_fresh = 1'b1; m_pc = in_pc; m_op = in_load_op; m_rfm = in_rfrom_mem;
            m_gr_we = in_gr_we; m_dest = in_dest; m_exe = in_exe_result;
          end
        end
        @(posedge clk); #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
